// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO pair.
// Operands are reduced to magnitudes up front; signs are reapplied in FIX.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mb_q, mb_d;
    logic [WIDTH-1:0]     raw_q, raw_d;
    logic                 is_div_q, is_div_d;
    logic                 dz_q, dz_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 busy_q, done_q, done_d, divz_q, divz_d;

    logic                 go, is_sgn;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum, div_trial;
    logic [2*WIDTH-1:0]   mul_nxt, div_nxt, prod_fix;
    logic [WIDTH-1:0]     quo, rem;

    assign go     = (state_q == S_IDLE) && start && !flush;
    assign is_sgn = !op[2] && !op[0];
    assign mag_a  = (is_sgn && srca[WIDTH-1]) ? -srca : srca;
    assign mag_b  = (is_sgn && srcb[WIDTH-1]) ? -srcb : srcb;

    // Multiply: multiplier sits in the low half and shifts out as the sum shifts in.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: {remainder, dividend/quotient}; quotient bits enter at the bottom.
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mb_q};
    assign div_nxt   = {div_trial[WIDTH] ? {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]}
                                         : div_trial[WIDTH-1:0],
                        acc_q[WIDTH-2:0], !div_trial[WIDTH]};

    assign prod_fix = negq_q ? -acc_q : acc_q;
    assign quo      = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem      = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (go && !op[2]) state_d = (op[1] && srcb == '0) ? S_FIX : S_RUN;
            S_RUN:  if (flush) state_d = S_IDLE;
                    else if (cnt_q == CW'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mb_d     = mb_q;
        raw_d    = raw_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        divz_d   = 1'b0;
        case (state_q)
            S_IDLE: if (go) begin
                if (op == 3'b100) hi_d = srca;
                if (op == 3'b101) lo_d = srca;
                if (!op[2]) begin
                    acc_d    = {{WIDTH{1'b0}}, mag_a};
                    mb_d     = mag_b;
                    raw_d    = srca;
                    is_div_d = op[1];
                    dz_d     = op[1] && (srcb == '0);
                    negq_d   = is_sgn && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                    negr_d   = is_sgn && srca[WIDTH-1];
                    cnt_d    = CW'(WIDTH);
                end
            end
            S_RUN: if (!flush) begin
                acc_d = is_div_q ? div_nxt : mul_nxt;
                cnt_d = cnt_q - CW'(1);
            end
            S_FIX: if (!flush) begin
                done_d = 1'b1;
                divz_d = dz_q;
                if (dz_q) begin
                    hi_d = raw_q;
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mb_q     <= '0;
            raw_q    <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mb_q     <= mb_d;
            raw_q    <= raw_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= done_d;
            divz_q   <= divz_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign divzero = divz_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed and randomized checks of muldiv_hilo_unit against an arithmetic reference.
module tb_muldiv_hilo_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [2:0]   op;
    logic [W-1:0] srca, srcb;
    logic         busy, done, divzero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_hilo_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .flush(flush), .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
        logic [63:0] p;
        longint x, y, q, r;
        edz = 1'b0;
        eh = '0;
        el = '0;
        if (o == 3'd0 || o == 3'd1) begin
            if (o == 3'd0) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            else           p = {32'b0, a} * {32'b0, b};
            eh = p[63:32];
            el = p[31:0];
        end else if (b == '0) begin
            eh = a; el = '1; edz = 1'b1;
        end else begin
            if (o == 3'd2) begin x = longint'($signed(a)); y = longint'($signed(b)); end
            else begin x = longint'({32'b0, a}); y = longint'({32'b0, b}); end
            q = x / y;
            r = x % y;
            el = W'(q);
            eh = W'(r);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic edz);
        logic [W-1:0] h0, l0;
        int cyc, bcnt;
        bit stable;
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        h0 = hi; l0 = lo; stable = 1; bcnt = 0;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        while (!done && cyc < W + 10) begin
            if (busy) bcnt++;
            if (hi !== h0 || lo !== l0) stable = 0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), edz ? 64'd2 : 64'(W + 2));
        chk({tag, " busy_cycles"}, 64'(bcnt), edz ? 64'd1 : 64'(W + 1));
        chk({tag, " hilo_stable"}, 64'(stable), 64'd1);
        chk({tag, " hi"}, 64'(hi), 64'(eh));
        chk({tag, " lo"}, 64'(lo), 64'(el));
        chk({tag, " divzero"}, 64'(divzero), 64'(edz));
        @(negedge clk);
        chk({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic no_done(input string tag, input int n, input logic [W-1:0] h0, input logic [W-1:0] l0);
        bit seen = 0;
        bit moved = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done || divzero) seen = 1;
            if (hi !== h0 || lo !== l0) moved = 1;
        end
        chk({tag, " no_done"}, 64'(seen), 64'd0);
        chk({tag, " hilo_kept"}, 64'(moved), 64'd0);
    endtask

    initial begin
        logic [W-1:0] eh, el, a, b, h0, l0;
        logic         edz;
        logic [2:0]   o;
        int           sel;

        reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; srca = '0; srcb = '0;
        repeat (3) @(negedge clk);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset divzero", 64'(divzero), 64'd0);
        reset = 1'b1;

        run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mult_m1m1", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0);
        run_op("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
        run_op("div_min_m1", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        run_op("divu_zero", 3'd3, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1);
        run_op("div_zero_neg", 3'd2, 32'hFFFF0000, 32'h0, 32'hFFFF0000, 32'hFFFFFFFF, 1'b1);

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        start = 1'b1; op = 3'd4; srca = 32'hA5A5A5A5;
        @(negedge clk);
        chk("mthi hi", 64'(hi), 64'hA5A5A5A5);
        chk("mthi busy", 64'(busy), 64'd0);
        op = 3'd5; srca = 32'h5A5A5A5A;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo lo", 64'(lo), 64'h5A5A5A5A);
        chk("mtlo hi_kept", 64'(hi), 64'hA5A5A5A5);
        chk("mtlo busy", 64'(busy), 64'd0);
        chk("mtlo done", 64'(done), 64'd0);

        // Reserved op 11x does nothing
        start = 1'b1; op = 3'd6; srca = 32'h1; srcb = 32'h1;
        @(negedge clk);
        start = 1'b0;
        chk("noop busy", 64'(busy), 64'd0);
        no_done("noop", 4, 32'hA5A5A5A5, 32'h5A5A5A5A);

        // Flush at RUN cycle 10
        start = 1'b1; op = 3'd0; srca = 32'd123; srcb = 32'd456;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush_run busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_run busy", 64'(busy), 64'd0);
        no_done("flush_run", W + 5, 32'hA5A5A5A5, 32'h5A5A5A5A);

        // Flush during FIX of a divide-by-zero
        start = 1'b1; op = 3'd3; srca = 32'h77; srcb = 32'h0;
        @(negedge clk);
        start = 1'b0; flush = 1'b1;
        chk("flush_fix busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_fix busy", 64'(busy), 64'd0);
        chk("flush_fix done", 64'(done), 64'd0);
        no_done("flush_fix", 4, 32'hA5A5A5A5, 32'h5A5A5A5A);

        // start and flush together in IDLE: nothing happens
        start = 1'b1; flush = 1'b1; op = 3'd4; srca = 32'hDEADBEEF;
        @(negedge clk);
        chk("startflush mthi hi", 64'(hi), 64'hA5A5A5A5);
        op = 3'd0; srca = 32'd5; srcb = 32'd6;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("startflush mult busy", 64'(busy), 64'd0);
        no_done("startflush", W + 4, 32'hA5A5A5A5, 32'h5A5A5A5A);

        // Randomized ops against the reference
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = '0;
            else if (sel == 1) b = 32'hFFFFFFFF;
            else if (sel == 2) a = 32'h80000000;
            else if (sel == 3) b = 32'($urandom_range(1, 15));
            model(o, a, b, eh, el, edz);
            run_op($sformatf("rand%0d op%0d", i, o), o, a, b, eh, el, edz);
        end

        // Asynchronous reset in RUN cycle 5 aborts the operation
        h0 = hi; l0 = lo;
        @(negedge clk);
        start = 1'b1; op = 3'd1; srca = 32'hFFFF; srcb = 32'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid busy_before", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid hi", 64'(hi), 64'd0);
        chk("rst_mid lo", 64'(lo), 64'd0);
        chk("rst_mid busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        no_done("rst_mid", W + 5, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
